// File: rtl/arb_burst_lock_mux_if.sv
// Bundles the requestor, arbiter and shared-channel signals of arb_burst_lock_mux.
// Latency: none; this is wiring only.
// Backpressure: carries valid/ready per requestor plus out_ready from downstream. ARB_BURST_TIMEOUT_EN adds timeout_err.
interface arb_burst_lock_mux_if #(
  parameter int NUM_REQUESTORS = 4,
  parameter int DATA_WIDTH     = 32
);
  localparam int OW = (NUM_REQUESTORS > 1) ? $clog2(NUM_REQUESTORS) : 1;

  logic [NUM_REQUESTORS-1:0]            req;
  logic [NUM_REQUESTORS-1:0]            arb_req;
  logic [NUM_REQUESTORS-1:0]            arb_grant;
  logic                                 arb_grant_valid;
  logic [NUM_REQUESTORS-1:0]            in_valid;
  logic [NUM_REQUESTORS*DATA_WIDTH-1:0] in_data;
  logic [NUM_REQUESTORS-1:0]            in_last;
  logic [NUM_REQUESTORS-1:0]            in_ready;
  logic                                 out_valid;
  logic [DATA_WIDTH-1:0]                out_data;
  logic                                 out_last;
  logic                                 out_ready;
  logic [OW-1:0]                        out_owner;
  logic                                 busy;
  logic                                 grant_err;
`ifdef ARB_BURST_TIMEOUT_EN
  logic                                 timeout_err;

  modport slave (
    input  req, arb_grant, arb_grant_valid, in_valid, in_data, in_last, out_ready,
    output arb_req, in_ready, out_valid, out_data, out_last, out_owner, busy, grant_err,
           timeout_err
  );
  modport master (
    output req, arb_grant, arb_grant_valid, in_valid, in_data, in_last, out_ready,
    input  arb_req, in_ready, out_valid, out_data, out_last, out_owner, busy, grant_err,
           timeout_err
  );
`else
  modport slave (
    input  req, arb_grant, arb_grant_valid, in_valid, in_data, in_last, out_ready,
    output arb_req, in_ready, out_valid, out_data, out_last, out_owner, busy, grant_err
  );
  modport master (
    output req, arb_grant, arb_grant_valid, in_valid, in_data, in_last, out_ready,
    input  arb_req, in_ready, out_valid, out_data, out_last, out_owner, busy, grant_err
  );
`endif
endinterface

// File: rtl/arb_burst_lock_mux.sv
// Locks the shared channel to the arbiter's one-hot winner for a whole burst; ARB_BURST_TIMEOUT_EN caps bursts at MAX_BURST beats.
// Latency: lock one edge after the grant; data path is combinational from the locked requestor.
// Backpressure: out_ready passes straight to in_ready of the owner; arb_req is held at zero while locked.
module arb_burst_lock_mux #(
  parameter int NUM_REQUESTORS = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int MAX_BURST      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  arb_burst_lock_mux_if.slave  bus
);
  localparam int OW = (NUM_REQUESTORS > 1) ? $clog2(NUM_REQUESTORS) : 1;

  if (MAX_BURST < 1) begin : g_bad_max_burst
    $error("MAX_BURST must be at least 1");
  end

  typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [OW-1:0]         r_owner;
  logic                  r_grant_err;
  logic [OW-1:0]         w_grant_idx;
  logic                  w_grant_onehot;
  logic                  w_lock;
  logic                  w_malformed;
  logic                  w_sel_valid;
  logic                  w_sel_last;
  logic [DATA_WIDTH-1:0] w_sel_data;
  logic                  w_xfer;
  logic                  w_timeout;
  logic                  w_release;

  // Decode the index of the granted requestor (meaningful only when one-hot)
  always_comb begin
    w_grant_idx = '0;
    for (int i = 0; i < NUM_REQUESTORS; i++) begin
      if (bus.arb_grant[i]) w_grant_idx = OW'(i);
    end
  end

  assign w_grant_onehot = $onehot(bus.arb_grant);
  // A stale one-hot grant (its requestor already dropped req) is silently ignored.
  assign w_lock      = (r_state == ST_IDLE) && bus.arb_grant_valid && w_grant_onehot &&
                       |(bus.arb_grant & bus.req);
  assign w_malformed = (r_state == ST_IDLE) && bus.arb_grant_valid && !w_grant_onehot;

  // Select the owner's beat stream
  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_last  = 1'b0;
    w_sel_data  = '0;
    for (int i = 0; i < NUM_REQUESTORS; i++) begin
      if (r_owner == OW'(i)) begin
        w_sel_valid = bus.in_valid[i];
        w_sel_last  = bus.in_last[i];
        w_sel_data  = bus.in_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign w_xfer    = (r_state == ST_BUSY) && w_sel_valid && bus.out_ready;
  assign w_release = w_xfer && (w_sel_last || w_timeout);

`ifdef ARB_BURST_TIMEOUT_EN
  localparam int CW = $clog2(MAX_BURST + 1);

  logic [CW-1:0] r_beat_cnt;
  logic          r_timeout_err;

  // The MAX_BURST-th beat without last closes the burst as though it carried last.
  assign w_timeout = !w_sel_last && (r_beat_cnt == CW'(MAX_BURST - 1));

  // Saturating beat counter and one-cycle timeout pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_beat_cnt    <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_timeout_err <= w_xfer && w_timeout;
      if (w_lock) begin
        r_beat_cnt <= '0;
      end else if (w_xfer && (r_beat_cnt != CW'(MAX_BURST))) begin
        r_beat_cnt <= r_beat_cnt + CW'(1);
      end
    end
  end

  assign bus.timeout_err = r_timeout_err;
`else
  assign w_timeout = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next state: grants are only looked at in IDLE, so one landing on the release edge is dropped
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_lock)    w_state_nxt = ST_BUSY;
      ST_BUSY: if (w_release) w_state_nxt = ST_IDLE;
      default:                w_state_nxt = ST_IDLE;
    endcase
  end

  // Owner capture and malformed-grant pulse; owner holds its value after release
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_owner     <= '0;
      r_grant_err <= 1'b0;
    end else begin
      r_grant_err <= w_malformed;
      if (w_lock) r_owner <= w_grant_idx;
    end
  end

  // Outputs: mux the owner while locked, otherwise forward req to the arbiter (held off during reset)
  always_comb begin
    bus.arb_req   = '0;
    bus.in_ready  = '0;
    bus.out_valid = 1'b0;
    bus.out_data  = '0;
    bus.out_last  = 1'b0;
    if (r_state == ST_BUSY) begin
      bus.out_valid = w_sel_valid;
      bus.out_data  = w_sel_data;
      bus.out_last  = w_sel_last;
      for (int i = 0; i < NUM_REQUESTORS; i++) begin
        bus.in_ready[i] = (r_owner == OW'(i)) && bus.out_ready;
      end
    end else if (rst) begin
      bus.arb_req = bus.req;
    end
  end

  assign bus.out_owner = r_owner;
  assign bus.busy      = (r_state == ST_BUSY);
  assign bus.grant_err = r_grant_err;

endmodule

// File: doc/arb_burst_lock_mux.md
Name: arb_burst_lock_mux

Overview:
- Sits directly downstream of the matrix arbiter. It consumes the arbiter's registered one-hot grant and locks the shared output channel to the winning requestor for a whole multi-beat burst.
- It multiplexes that requestor's valid/data/last stream onto one output with a valid/ready handshake, and releases ownership on the last beat.
- It also gates the request vector sent to the arbiter, so no new arbitration occurs while a burst is in flight.

Parameters:
- NUM_REQUESTORS, 4, number of requestors; must match the arbiter instance.
- DATA_WIDTH, 32, payload width per beat.
- MAX_BURST, 16, maximum beats per burst; used only when the optional feature is compiled in; must be >= 1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- req  in  NUM_REQUESTORS  requestor i wants to start a burst.
- arb_req  out  NUM_REQUESTORS  request vector driven to the arbiter.
- arb_grant  in  NUM_REQUESTORS  arbiter grant vector, registered, expected one-hot.
- arb_grant_valid  in  1  arbiter grant_valid.
- in_valid  in  NUM_REQUESTORS  per-requestor beat valid.
- in_data  in  NUM_REQUESTORS*DATA_WIDTH  per-requestor beat data; requestor i occupies [i*DATA_WIDTH +: DATA_WIDTH].
- in_last  in  NUM_REQUESTORS  per-requestor last-beat flag.
- in_ready  out  NUM_REQUESTORS  per-requestor beat accept.
- out_valid  out  1  shared channel beat valid.
- out_data  out  DATA_WIDTH  shared channel data.
- out_last  out  1  shared channel last flag.
- out_ready  in  1  downstream accept.
- out_owner  out  clog2(NUM_REQUESTORS), minimum 1  index of the locked requestor.
- busy  out  1  a burst is locked.
- grant_err  out  1  one-cycle pulse: a malformed grant was received in IDLE.

Behaviour:
- Reset (rst low, asynchronous):
  - state=IDLE, owner=0, beat count=0.
  - busy=0, grant_err=0, out_valid=0, in_ready=0, arb_req=0.
- States: IDLE and BUSY, held in registered state.
- IDLE:
  - arb_req = req.
  - out_valid=0, in_ready all 0.
- IDLE -> BUSY on a rising edge when all of the following hold:
  - arb_grant_valid=1;
  - arb_grant is exactly one-hot, index k;
  - req[k]=1.
  - On transition: owner<=k, beat count<=0, busy<=1.
- Stale grant (one-hot but req[k]=0): ignored, stay IDLE, no error.
- Malformed grant (arb_grant_valid=1 and arb_grant zero or multi-hot) in IDLE:
  - grant_err pulses high for exactly one cycle (registered).
  - Stay IDLE.
- BUSY:
  - arb_req = 0, so the arbiter produces no new winner.
  - Combinational mux from owner: out_valid=in_valid[owner], out_data=in_data slice[owner], out_last=in_last[owner].
  - in_ready[owner]=out_ready; all other in_ready bits are 0.
  - out_owner=owner.
  - arb_grant and arb_grant_valid are ignored in BUSY; the arbiter's in-flight grant, registered from the pre-lock cycle, must not disturb ownership.
- Beat transfer = out_valid & out_ready. Each transfer increments the beat count; the count saturates and does not wrap.
- BUSY -> IDLE on the edge where a transfer occurs with out_last=1. busy<=0.
- After release, the arbiter sees the restored arb_req. The earliest new lock is 2 cycles after release (arbiter register latency). No beat of the new owner passes in the release cycle.
- Simultaneous release and grant: a grant present on the release edge is ignored, because the state is still BUSY.
- out_owner holds its last value in IDLE.
- Reset mid-burst: ownership is dropped immediately; in_ready and out_valid go low asynchronously.

Optional Feature:
- Macro: ARB_BURST_TIMEOUT_EN.
- Defined:
  - Adds an output timeout_err (1 bit).
  - If the beat count reaches MAX_BURST without a last beat, the lock is forcibly released. This happens on the edge of the MAX_BURST-th transfer, exactly as if out_last were 1.
  - timeout_err pulses for one cycle on that edge.
  - Transfers with out_last=1 on or before beat MAX_BURST release normally with no error.
- Undefined:
  - No timeout_err port; bursts are unbounded.
  - The beat counter may be optimised away.

Test Plan:
- Lock and release:
  - Stimulus: req=0010, arbiter grants 0010; owner streams 3 beats (last on beat 3) with out_ready=1.
  - Required: busy=1 for exactly 3 cycles, out_owner=1, out_data follows requestor 1, arb_req=0000 while busy, busy=0 after beat 3.
- Backpressure:
  - Stimulus: same burst with out_ready toggling 1,0,1,0,1.
  - Required: in_ready[1] mirrors out_ready; no beat is lost or duplicated; release only on the edge where the last beat transfers.
- Stale and malformed grants:
  - Stimulus: in IDLE, grant 0100 with req[2]=0.
  - Required: no lock, grant_err=0.
  - Stimulus: grant 0110 with arb_grant_valid=1.
  - Required: grant_err high for 1 cycle, stays IDLE.
- Grant while busy:
  - Stimulus: owner 0 busy; arbiter presents grant 1000 mid-burst and again on the release edge.
  - Required: owner unchanged; returns to IDLE; the next lock happens only after a fresh arbiter grant.
- Reset mid-burst:
  - Stimulus: drive rst=0 asynchronously during beat 2 of 4.
  - Required: busy, out_valid, in_ready and arb_req are 0 immediately; after rst=1, state is IDLE and arb_req=req.
- Timeout (ARB_BURST_TIMEOUT_EN, MAX_BURST=4):
  - Stimulus: owner streams 6 beats, never asserting last.
  - Required: release after beat 4, timeout_err pulses 1 cycle, beats 5-6 are not accepted until a re-grant.
